instr_fetch_issue: RTL
======================

// Module: instr_fetch_issue
// PURPOSE
//  Front-end producer for the instruction queue: fetches one 32-bit instruction at a
//  time from the I-side memory port, decodes it into a tomasula_types::ctl_word plus an
//  rv32i_types::rvfi_word, and pushes both with an ld/ack handshake. Sits between I-cache
//  and issue queue; redirects to a new PC on a branch-unit flush.
// PARAMETERS
//  RESET_PC  32'h4000_0060  fetch address after reset
// PORTS
//  clk             in   1   clock (sole clock domain)
//  rst             in   1   asynchronous, active-high reset
//  imem_address    out  32  fetch address (= fetch_pc, word aligned)
//  imem_read       out  1   fetch request, held until imem_resp
//  imem_rdata      in   32  instruction word, valid with imem_resp
//  imem_resp       in   1   1-cycle read completion
//  flush_i         in   1   redirect request from branch unit
//  flush_pc_i      in   32  redirect target, sampled when flush_i=1
//  iq_full_n_i     in   1   queue has space (informational; ack_i governs transfer)
//  ld_iq_o         out  1   control_word_o/rvfi_o valid, request enqueue
//  ack_i           in   1   queue accepted the word this cycle
//  control_word_o  out  ctl_word   decoded control word
//  rvfi_o          out  rvfi_word  monitor word (pc_rdata, pc_wdata, inst, rs/rd addrs)
// BEHAVIOUR
//  State: FETCH, PUSH, DROP. Reset (async): state=FETCH, fetch_pc=RESET_PC, instr reg=0.
//  Outputs during rst: imem_read=0, ld_iq_o=0, control_word_o/rvfi_o all-zero.
//  FETCH: imem_read=1, imem_address=fetch_pc. On imem_resp: latch imem_rdata -> PUSH.
//  PUSH: ld_iq_o=1; control_word_o/rvfi_o combinational decode of latched instr, stable
//   while ack_i=0. On ack_i: fetch_pc<=fetch_pc+4 (mod 2^32) -> FETCH. 1 word per ack.
//   Minimum throughput: 1 instr per 2 cycles + memory latency.
//  Decode: og_pc=fetch_pc; og_instr=instr; pc(next)=fetch_pc+4 (static not-taken).
//   JAL/JALR/BRANCH -> op=BRANCH; LOAD/STORE/OP/OP-IMM/LUI/AUIPC -> matching op
//   (op[3]=1 for ops with no rd write, e.g. STORE). src1_reg=instr[19:15],
//   src1_valid=1 if op uses rs1; src2_reg=instr[24:20], src2_valid=1 for OP/STORE/BRANCH;
//   src2_data=sign-extended immediate of the format (U-type: imm<<12); funct3=instr[14:12];
//   funct7=instr[30]; rd=instr[11:7], forced 0 for STORE/BRANCH.
//  Flush (priority over all other events, effective same edge):
//   FETCH, no imem_resp same cycle: request outstanding -> DROP, pending_pc<=flush_pc_i.
//   FETCH with imem_resp same cycle: discard rdata, fetch_pc<=flush_pc_i -> FETCH.
//   PUSH (with or without ack_i): discard word, fetch_pc<=flush_pc_i -> FETCH; ld_iq_o
//    deasserts next cycle (queue discards the acked word on flush).
//   DROP: imem_read held at old address until imem_resp (memory not abortable);
//    further flush updates pending_pc; on imem_resp discard data, fetch_pc<=pending_pc
//    -> FETCH.
//  imem_address never changes while imem_read=1 and imem_resp=0.
//  Reset mid-operation: immediate return to reset values; an outstanding memory
//   request is abandoned (memory is reset with the core).
// TESTING
//  1 Reset release -> imem_read=1, imem_address=0x4000_0060, ld_iq_o=0.
//  2 imem_resp, rdata=0x0050_0093 (addi x1,x0,5) -> next cycle ld_iq_o=1, rd=1,
//    src1_reg=0, src1_valid=1, src2_data=5, og_pc=0x4000_0060, pc=0x4000_0064;
//    ack_i -> FETCH at 0x4000_0064.
//  3 Backpressure: ack_i low 5 cycles in PUSH -> ld_iq_o and control_word_o bit-stable;
//    no imem_read asserted.
//  4 flush_i (pc 0x4000_1000) 1 cycle after fetch issue, resp 3 cycles later ->
//    address held until resp, data dropped, next fetch at 0x4000_1000, no ld_iq_o.
//  5 flush_i and ack_i same cycle in PUSH -> next fetch at flush_pc_i, not pc+4.
//  6 rst asserted mid-PUSH (async, between edges) -> ld_iq_o=0 immediately; after
//    release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: fetches one word from the I-side port, decodes it
// into a control word plus a monitor word, and hands both to the issue queue.

package rv32i_types;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } rvfi_word;
endpackage

package tomasula_types;
    // Bit 3 set marks operations that never write a destination register.
    typedef enum logic [3:0] {
        CTL_LUI    = 4'h0,
        CTL_AUIPC  = 4'h1,
        CTL_LOAD   = 4'h2,
        CTL_ARITH  = 4'h3,
        CTL_REG    = 4'h4,
        CTL_BRANCH = 4'h5,
        CTL_STORE  = 4'h8,
        CTL_NOP    = 4'hF
    } ctl_op_e;

    typedef struct packed {
        ctl_op_e     op;
        logic [31:0] og_pc;
        logic [31:0] og_instr;
        logic [31:0] pc;
        logic [4:0]  src1_reg;
        logic        src1_valid;
        logic [4:0]  src2_reg;
        logic        src2_valid;
        logic [31:0] src2_data;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  rd;
    } ctl_word;
endpackage

module instr_fetch_issue
    import rv32i_types::*;
    import tomasula_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        iq_full_n_i,
    output logic        ld_iq_o,
    input  logic        ack_i,
    output ctl_word     control_word_o,
    output rvfi_word    rvfi_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        PUSH  = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] instr_q, instr_d;

    // Queue space is advisory only; ack_i alone governs the transfer.
    logic unused_iq_full_n;
    assign unused_iq_full_n = iq_full_n_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            instr_q      <= instr_d;
        end
    end

    // NOTE: every output of this process is defaulted first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        instr_d      = instr_q;

        unique case (state_q)
            FETCH: begin
                if (imem_resp) begin
                    if (flush_i) begin
                        fetch_pc_d = flush_pc_i;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = PUSH;
                    end
                end else if (flush_i) begin
                    // The memory cannot abort, so wait out the stale response.
                    pending_pc_d = flush_pc_i;
                    state_d      = DROP;
                end
            end
            PUSH: begin
                if (flush_i) begin
                    fetch_pc_d = flush_pc_i;
                    state_d    = FETCH;
                end else if (ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                if (flush_i) begin
                    pending_pc_d = flush_pc_i;
                end
                if (imem_resp) begin
                    fetch_pc_d = flush_i ? flush_pc_i : pending_pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Address stays on fetch_pc_q through DROP, so it is stable while a request is open.
    assign imem_address = fetch_pc_q;
    assign imem_read    = !rst && (state_q != PUSH);
    assign ld_iq_o      = !rst && (state_q == PUSH);

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        uses_rs1, uses_rs2, no_rd;
    ctl_word     ctl_dec;
    rvfi_word    rvfi_dec;

    assign opcode = instr_q[6:0];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};
    assign imm_u  = {instr_q[31:12], 12'h000};
    assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                     instr_q[30:21], 1'b0};

    always_comb begin
        ctl_dec   = '0;
        rvfi_dec  = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        no_rd     = 1'b0;
        ctl_dec.op = CTL_NOP;

        unique case (opcode)
            OPC_LUI:    begin ctl_dec.op = CTL_LUI;    ctl_dec.src2_data = imm_u; end
            OPC_AUIPC:  begin ctl_dec.op = CTL_AUIPC;  ctl_dec.src2_data = imm_u; end
            OPC_JAL:    begin ctl_dec.op = CTL_BRANCH; ctl_dec.src2_data = imm_j; end
            OPC_JALR: begin
                ctl_dec.op        = CTL_BRANCH;
                ctl_dec.src2_data = imm_i;
                uses_rs1          = 1'b1;
            end
            OPC_BRANCH: begin
                ctl_dec.op        = CTL_BRANCH;
                ctl_dec.src2_data = imm_b;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                no_rd             = 1'b1;
            end
            OPC_LOAD: begin
                ctl_dec.op        = CTL_LOAD;
                ctl_dec.src2_data = imm_i;
                uses_rs1          = 1'b1;
            end
            OPC_STORE: begin
                ctl_dec.op        = CTL_STORE;
                ctl_dec.src2_data = imm_s;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                no_rd             = 1'b1;
            end
            OPC_IMM: begin
                ctl_dec.op        = CTL_ARITH;
                ctl_dec.src2_data = imm_i;
                uses_rs1          = 1'b1;
            end
            OPC_REG: begin
                ctl_dec.op = CTL_REG;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            default: begin
                no_rd = 1'b1;
            end
        endcase

        // Static not-taken prediction: the successor is always fetch_pc + 4.
        ctl_dec.og_pc      = fetch_pc_q;
        ctl_dec.og_instr   = instr_q;
        ctl_dec.pc         = fetch_pc_q + 32'd4;
        ctl_dec.src1_reg   = instr_q[19:15];
        ctl_dec.src1_valid = uses_rs1;
        ctl_dec.src2_reg   = instr_q[24:20];
        ctl_dec.src2_valid = uses_rs2;
        ctl_dec.funct3     = instr_q[14:12];
        ctl_dec.funct7     = instr_q[30];
        ctl_dec.rd         = no_rd ? 5'd0 : instr_q[11:7];

        rvfi_dec.inst      = instr_q;
        rvfi_dec.pc_rdata  = fetch_pc_q;
        rvfi_dec.pc_wdata  = fetch_pc_q + 32'd4;
        rvfi_dec.rs1_addr  = uses_rs1 ? instr_q[19:15] : 5'd0;
        rvfi_dec.rs2_addr  = uses_rs2 ? instr_q[24:20] : 5'd0;
        rvfi_dec.rd_addr   = ctl_dec.rd;
    end

    assign control_word_o = ld_iq_o ? ctl_dec : '0;
    assign rvfi_o         = ld_iq_o ? rvfi_dec : '0;

endmodule
